// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and sizes for the register-file write arbiter.
// Holds the register geometry and the write-request record used by both
// the secondary queue and the registered write-port stage.
package regfile_write_arbiter_pkg;

    localparam int REGISTER_WIDTH = 32;
    localparam int REGISTER_DEPTH = 32;
    localparam int ADDR_WIDTH     = $clog2(REGISTER_DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]     addr;
        logic [REGISTER_WIDTH-1:0] data;
    } regfile_write_t;

    // Register 0 is hard-wired: a request to it is consumed but never written.
    function automatic logic writes_register(input regfile_write_t w);
        return (w.addr != {ADDR_WIDTH{1'b0}});
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_fifo.sv
// rf_write_fifo: circular buffer of pending secondary register writes.
// Exposes every slot and its valid bit so the top can build the
// pending-destination mask. Push is ignored when full, pop when empty.
module rf_write_fifo
    import regfile_write_arbiter_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  regfile_write_t             push_entry,
    input  logic                       pop,
    output regfile_write_t             head,
    output logic [CNT_W-1:0]           count,
    output regfile_write_t [DEPTH-1:0] entries,
    output logic [DEPTH-1:0]           valid_bits
);

    logic [PTR_W-1:0]           wr_ptr_r;
    logic [PTR_W-1:0]           rd_ptr_r;
    logic [CNT_W-1:0]           count_r;
    regfile_write_t [DEPTH-1:0] mem_r;
    logic [DEPTH-1:0]           valid_r;
    logic                       do_push_s;
    logic                       do_pop_s;

    assign do_push_s  = push && (count_r < CNT_W'(DEPTH));
    assign do_pop_s   = pop && (count_r != {CNT_W{1'b0}});
    assign head       = mem_r[rd_ptr_r];
    assign count      = count_r;
    assign entries    = mem_r;
    assign valid_bits = valid_r;

    // Pointer and occupancy bookkeeping; pointers wrap as DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Slot storage and per-slot valid bits; push and pop never hit the same slot
    // because a pop needs a non-empty queue and a push needs a non-full one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_r   <= '0;
            valid_r <= {DEPTH{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r]   <= push_entry;
                valid_r[wr_ptr_r] <= 1'b1;
            end
            if (do_pop_s) begin
                valid_r[rd_ptr_r] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the single register-file write port between
// the in-order writeback stage (primary) and queued long-latency results
// (secondary). Primary wins; secondary entries drain into idle cycles.
// Optional starvation guard: define REGFILE_ARB_STARVE_GUARD_EN to force a
// secondary grant after STARVE_LIMIT consecutive denied cycles.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter  int FIFO_DEPTH   = 4,
    parameter  int STARVE_LIMIT = 8,
    localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pri_valid,
    output logic                      pri_ready,
    input  logic [ADDR_WIDTH-1:0]     pri_addr,
    input  logic [REGISTER_WIDTH-1:0] pri_data,
    input  logic                      sec_valid,
    output logic                      sec_ready,
    input  logic [ADDR_WIDTH-1:0]     sec_addr,
    input  logic [REGISTER_WIDTH-1:0] sec_data,
    output logic                      wr_enable,
    output logic [ADDR_WIDTH-1:0]     wr_address,
    output logic [REGISTER_WIDTH-1:0] wr_data,
    output logic [REGISTER_DEPTH-1:0] pending_mask,
    output logic [CNT_W-1:0]          fifo_count
);

    regfile_write_t                  head_s;
    regfile_write_t [FIFO_DEPTH-1:0] entries_s;
    logic [FIFO_DEPTH-1:0]           valid_bits_s;
    logic                            push_s;
    logic                            pop_s;
    logic                            fifo_empty_s;
    logic                            force_sec_s;
    logic                            grant_valid_s;
    regfile_write_t                  grant_entry_s;
    logic                            wr_enable_r;
    logic [ADDR_WIDTH-1:0]           wr_address_r;
    logic [REGISTER_WIDTH-1:0]       wr_data_r;

    // Readiness only looks at registered occupancy: a same-cycle pop never frees a slot.
    assign sec_ready    = rst && (fifo_count < CNT_W'(FIFO_DEPTH));
    assign push_s       = sec_valid && sec_ready;
    assign fifo_empty_s = (fifo_count == {CNT_W{1'b0}});
    assign pri_ready    = rst && !force_sec_s;

    rf_write_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_s),
        .push_entry ({sec_addr, sec_data}),
        .pop        (pop_s),
        .head       (head_s),
        .count      (fifo_count),
        .entries    (entries_s),
        .valid_bits (valid_bits_s)
    );

`ifdef REGFILE_ARB_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    logic [STARVE_W-1:0] starve_cnt_r;

    // Force the queue head through once primary has starved it for the limit.
    always_comb begin
        force_sec_s = 1'b0;
        if ((starve_cnt_r == STARVE_W'(STARVE_LIMIT)) && !fifo_empty_s) begin
            force_sec_s = 1'b1;
        end else begin
            force_sec_s = 1'b0;
        end
    end

    // Count consecutive cycles where a queued entry lost to primary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_r <= {STARVE_W{1'b0}};
        end else if (pop_s || fifo_empty_s) begin
            starve_cnt_r <= {STARVE_W{1'b0}};
        end else if (pri_valid) begin
            starve_cnt_r <= starve_cnt_r + STARVE_W'(1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end
`else
    assign force_sec_s = 1'b0;
`endif

    // Per-cycle grant: forced secondary, then primary, then queue drain, else idle.
    always_comb begin
        pop_s         = 1'b0;
        grant_valid_s = 1'b0;
        grant_entry_s = '0;
        if (!rst) begin
            grant_valid_s = 1'b0;
        end else if (force_sec_s) begin
            pop_s         = 1'b1;
            grant_valid_s = 1'b1;
            grant_entry_s = head_s;
        end else if (pri_valid) begin
            grant_valid_s = 1'b1;
            grant_entry_s = {pri_addr, pri_data};
        end else if (!fifo_empty_s) begin
            pop_s         = 1'b1;
            grant_valid_s = 1'b1;
            grant_entry_s = head_s;
        end else begin
            grant_valid_s = 1'b0;
        end
    end

    // Register the granted write; requests to register 0 are dropped here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_enable_r  <= 1'b0;
            wr_address_r <= {ADDR_WIDTH{1'b0}};
            wr_data_r    <= {REGISTER_WIDTH{1'b0}};
        end else if (grant_valid_s) begin
            wr_enable_r  <= writes_register(grant_entry_s);
            wr_address_r <= grant_entry_s.addr;
            wr_data_r    <= grant_entry_s.data;
        end else begin
            wr_enable_r  <= 1'b0;
        end
    end

    assign wr_enable  = wr_enable_r;
    assign wr_address = wr_address_r;
    assign wr_data    = wr_data_r;

    // Destination mask of every queued write; register 0 never needs a stall.
    always_comb begin
        pending_mask = {REGISTER_DEPTH{1'b0}};
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (valid_bits_s[i]) begin
                pending_mask[entries_s[i].addr] = 1'b1;
            end else begin
                pending_mask[entries_s[i].addr] = pending_mask[entries_s[i].addr];
            end
        end
        pending_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter (default build, guard disabled).
// Expected register-file writes are queued as stimulus is issued; a monitor
// pops and compares each time the DUT strobes wr_enable.
module tb_regfile_write_arbiter;
    import regfile_write_arbiter_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      pri_valid;
    logic                      pri_ready;
    logic [ADDR_WIDTH-1:0]     pri_addr;
    logic [REGISTER_WIDTH-1:0] pri_data;
    logic                      sec_valid;
    logic                      sec_ready;
    logic [ADDR_WIDTH-1:0]     sec_addr;
    logic [REGISTER_WIDTH-1:0] sec_data;
    logic                      wr_enable;
    logic [ADDR_WIDTH-1:0]     wr_address;
    logic [REGISTER_WIDTH-1:0] wr_data;
    logic [REGISTER_DEPTH-1:0] pending_mask;
    logic [2:0]                fifo_count;

    int checks   = 0;
    int failures = 0;
    regfile_write_t exp_q[$];
    regfile_write_t mon_e;

    always #5 clk = ~clk;

    regfile_write_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .pri_valid    (pri_valid),
        .pri_ready    (pri_ready),
        .pri_addr     (pri_addr),
        .pri_data     (pri_data),
        .sec_valid    (sec_valid),
        .sec_ready    (sec_ready),
        .sec_addr     (sec_addr),
        .sec_data     (sec_data),
        .wr_enable    (wr_enable),
        .wr_address   (wr_address),
        .wr_data      (wr_data),
        .pending_mask (pending_mask),
        .fifo_count   (fifo_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst === 1'b1 && wr_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                         wr_address, wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_addr", 64'(wr_address), 64'(mon_e.addr));
                check("sb_data", 64'(wr_data), 64'(mon_e.data));
            end
        end
    end

    initial begin
        rst = 1'b0; pri_valid = 1'b0; pri_addr = 5'd0; pri_data = 32'd0;
        sec_valid = 1'b0; sec_addr = 5'd0; sec_data = 32'd0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wr_enable",  64'(wr_enable),    64'd0);
        check("rst_wr_address", 64'(wr_address),   64'd0);
        check("rst_wr_data",    64'(wr_data),      64'd0);
        check("rst_fifo_count", 64'(fifo_count),   64'd0);
        check("rst_pending",    64'(pending_mask), 64'd0);
        check("rst_pri_ready",  64'(pri_ready),    64'd0);
        check("rst_sec_ready",  64'(sec_ready),    64'd0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("idle_pri_ready", 64'(pri_ready), 64'd1);
        check("idle_sec_ready", 64'(sec_ready), 64'd1);
        check("idle_wr_enable", 64'(wr_enable), 64'd0);

        // Primary only: write appears the next cycle
        tick();
        pri_valid = 1'b1; pri_addr = 5'd5; pri_data = 32'hDEADBEEF;
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        @(negedge clk);
        check("pri_ready", 64'(pri_ready), 64'd1);
        tick();
        pri_valid = 1'b0;
        @(negedge clk);
        check("pri_lat_wr_enable", 64'(wr_enable), 64'd1);
        check("pri_lat_wr_address", 64'(wr_address), 64'd5);

        // Secondary drain: push rd7 then rd9 with primary idle
        tick();
        sec_valid = 1'b1; sec_addr = 5'd7; sec_data = 32'h11;
        exp_q.push_back({5'd7, 32'h11});
        @(negedge clk);
        check("drain_count0", 64'(fifo_count), 64'd0);
        tick();
        sec_addr = 5'd9; sec_data = 32'h22;
        exp_q.push_back({5'd9, 32'h22});
        @(negedge clk);
        check("drain_count1", 64'(fifo_count), 64'd1);
        check("drain_mask7", 64'(pending_mask), 64'h80);
        check("drain_no_bypass", 64'(wr_enable), 64'd0);
        tick();
        sec_valid = 1'b0;
        @(negedge clk);
        check("drain_count2", 64'(fifo_count), 64'd1);
        check("drain_mask9", 64'(pending_mask), 64'h200);
        check("drain_wr7_lat", 64'(wr_enable), 64'd1);
        tick();
        @(negedge clk);
        check("drain_count3", 64'(fifo_count), 64'd0);
        check("drain_mask0", 64'(pending_mask), 64'd0);

        // FIFO full while primary (to x0) holds the port
        tick();
        pri_valid = 1'b1; pri_addr = 5'd0; pri_data = 32'h5555;
        for (int i = 1; i <= 4; i++) begin
            sec_valid = 1'b1; sec_addr = 5'(i); sec_data = 32'hA0 + 32'(i);
            exp_q.push_back({5'(i), 32'hA0 + 32'(i)});
            @(negedge clk);
            check("full_sec_ready_fill", 64'(sec_ready), 64'd1);
            tick();
        end
        sec_valid = 1'b1; sec_addr = 5'd10; sec_data = 32'hBAD;
        @(negedge clk);
        check("full_count", 64'(fifo_count), 64'd4);
        check("full_sec_ready", 64'(sec_ready), 64'd0);
        check("full_mask", 64'(pending_mask), 64'h1E);
        check("full_pri_ready", 64'(pri_ready), 64'd1);
        repeat (3) tick();
        @(negedge clk);
        check("full_no_fifth", 64'(fifo_count), 64'd4);
        check("full_no_drain_wr", 64'(wr_enable), 64'd0);
        tick();
        pri_valid = 1'b0; sec_valid = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        check("full_drained", 64'(fifo_count), 64'd0);

        // Primary and secondary in the same cycle: primary written first
        tick();
        pri_valid = 1'b1; pri_addr = 5'd3; pri_data = 32'h33;
        sec_valid = 1'b1; sec_addr = 5'd12; sec_data = 32'h44;
        exp_q.push_back({5'd3, 32'h33});
        exp_q.push_back({5'd12, 32'h44});
        tick();
        pri_valid = 1'b0; sec_valid = 1'b0;
        @(negedge clk);
        check("mix_wr_addr_pri", 64'(wr_address), 64'd3);
        check("mix_mask12", 64'(pending_mask), 64'h1000);
        tick();
        @(negedge clk);
        check("mix_wr_addr_sec", 64'(wr_address), 64'd12);

        // x0 handling, primary then secondary
        tick();
        pri_valid = 1'b1; pri_addr = 5'd0; pri_data = 32'h77;
        @(negedge clk);
        check("x0_pri_ready", 64'(pri_ready), 64'd1);
        tick();
        pri_valid = 1'b0;
        sec_valid = 1'b1; sec_addr = 5'd0; sec_data = 32'h88;
        @(negedge clk);
        check("x0_pri_no_write", 64'(wr_enable), 64'd0);
        tick();
        sec_valid = 1'b0;
        @(negedge clk);
        check("x0_sec_count", 64'(fifo_count), 64'd1);
        check("x0_sec_mask", 64'(pending_mask), 64'd0);
        tick();
        @(negedge clk);
        check("x0_sec_popped", 64'(fifo_count), 64'd0);
        check("x0_sec_no_write", 64'(wr_enable), 64'd0);

        // Reset mid-operation flushes the queue
        tick();
        pri_valid = 1'b1; pri_addr = 5'd0;
        sec_valid = 1'b1; sec_addr = 5'd20; sec_data = 32'h99;
        tick();
        sec_valid = 1'b0;
        @(negedge clk);
        check("mid_count", 64'(fifo_count), 64'd1);
        check("mid_mask20", 64'(pending_mask), 64'h100000);
        rst = 1'b0;
        #2;
        check("mid_rst_count", 64'(fifo_count), 64'd0);
        check("mid_rst_mask", 64'(pending_mask), 64'd0);
        check("mid_rst_pri_ready", 64'(pri_ready), 64'd0);
        check("mid_rst_sec_ready", 64'(sec_ready), 64'd0);
        tick();
        rst = 1'b1; pri_valid = 1'b0;
        @(negedge clk);
        check("mid_after_count", 64'(fifo_count), 64'd0);
        repeat (3) tick();

        // Bounded wait for every expected write to be seen
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        check("sb_all_writes_seen", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
